// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Per-channel synchroniser with registered edge pulses and
//               sticky event flags; optional debounce filter via DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] a_level,
  output logic [WIDTH-1:0] a_posedge,
  output logic [WIDTH-1:0] a_negedge,
  output logic [WIDTH-1:0] a_bothedge,
  output logic [WIDTH-1:0] evt_pos,
  output logic [WIDTH-1:0] evt_neg
);

  if (WIDTH < 1 || WIDTH > 32 || STAGES < 2 || STAGES > 4 ||
      DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_param_check
    $error("sync_edge_det: parameter out of legal range");
  end

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             w_sync;
  logic [WIDTH-1:0]             w_filt;
  logic [WIDTH-1:0]             r_filt_d;
  logic [WIDTH-1:0]             w_rise;
  logic [WIDTH-1:0]             w_fall;
  logic [WIDTH-1:0]             r_pos;
  logic [WIDTH-1:0]             r_neg;
  logic [WIDTH-1:0]             r_both;
  logic [WIDTH-1:0]             r_evt_pos;
  logic [WIDTH-1:0]             r_evt_neg;

  // Stage 0 captures the raw asynchronous input; the last stage is usable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], a};
    end
  end

  assign w_sync = r_sync[STAGES-1];

`ifdef DEBOUNCE_EN
  localparam logic [7:0] c_DB_LAST = 8'(DB_CYCLES - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    logic [7:0] r_cnt;
    logic       r_filt;

    // Level only follows the synchronised input after DB_CYCLES stable cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_filt <= 1'b0;
      end else if (w_sync[gi] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DB_LAST) begin
        r_filt <= w_sync[gi];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end

    assign w_filt[gi] = r_filt;
  end
`else
  assign w_filt = w_sync;
`endif

  assign w_rise = w_filt & ~r_filt_d;
  assign w_fall = ~w_filt & r_filt_d;

  // Sticky flags: a new event on the same edge as clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_d  <= '0;
      r_pos     <= '0;
      r_neg     <= '0;
      r_both    <= '0;
      r_evt_pos <= '0;
      r_evt_neg <= '0;
    end else begin
      r_filt_d  <= w_filt;
      r_pos     <= w_rise;
      r_neg     <= w_fall;
      r_both    <= w_rise | w_fall;
      r_evt_pos <= (r_evt_pos & ~clr) | w_rise;
      r_evt_neg <= (r_evt_neg & ~clr) | w_fall;
    end
  end

  assign a_level    = w_filt;
  assign a_posedge  = r_pos;
  assign a_negedge  = r_neg;
  assign a_bothedge = r_both;
  assign evt_pos    = r_evt_pos;
  assign evt_neg    = r_evt_neg;

endmodule
`default_nettype wire

// File: tb/tb_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_edge_det
// Description : Directed self-checking bench for sync_edge_det (WIDTH=4,
//               STAGES=2, DB_CYCLES=4); timing adapts when DEBOUNCE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_edge_det;

  localparam int c_WIDTH  = 4;
  localparam int c_STAGES = 2;
  localparam int c_DB     = 4;
`ifdef DEBOUNCE_EN
  localparam int c_DBX    = c_DB;
`else
  localparam int c_DBX    = 0;
`endif
  localparam int c_LAT    = c_STAGES + c_DBX;  // edges until a_level moves
  localparam int c_H      = 2 + c_DBX;         // pulse width that survives the filter

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [c_WIDTH-1:0] a = '0;
  logic [c_WIDTH-1:0] clr = '0;
  logic [c_WIDTH-1:0] a_level, a_posedge, a_negedge, a_bothedge, evt_pos, evt_neg;

  int n_pass  = 0;
  int n_total = 0;

  sync_edge_det #(
    .WIDTH    (c_WIDTH),
    .STAGES   (c_STAGES),
    .DB_CYCLES(c_DB)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .clr       (clr),
    .a_level   (a_level),
    .a_posedge (a_posedge),
    .a_negedge (a_negedge),
    .a_bothedge(a_bothedge),
    .evt_pos   (evt_pos),
    .evt_neg   (evt_neg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] all_out();
    return {8'h00, a_level, a_posedge, a_negedge, a_bothedge, evt_pos, evt_neg};
  endfunction

  initial begin
    // Reset state
    step();
    step();
    check("reset_all", all_out(), 32'h0);

    // Single rising channel after release
    rst_n = 1'b1;
    a     = 4'b0001;
    for (int k = 1; k <= c_LAT + 2; k++) begin
      step();
      check($sformatf("rise0_level_k%0d", k), 32'(a_level), (k >= c_LAT) ? 32'h1 : 32'h0);
      check($sformatf("rise0_pos_k%0d", k), 32'(a_posedge), (k == c_LAT + 1) ? 32'h1 : 32'h0);
      check($sformatf("rise0_evtpos_k%0d", k), 32'(evt_pos), (k >= c_LAT + 1) ? 32'h1 : 32'h0);
      check($sformatf("rise0_neg_k%0d", k), 32'(a_negedge), 32'h0);
    end

    // Clear leaves level alone
    clr = 4'b0001;
    step();
    clr = 4'b0000;
    check("clr0_evtpos", 32'(evt_pos), 32'h0);
    check("clr0_level", 32'(a_level), 32'h1);

    // Short pulse on channel 1
    a[1] = 1'b1;
    for (int k = 1; k <= c_LAT + c_H + 2; k++) begin
      step();
      if (k == c_H) a[1] = 1'b0;
      check($sformatf("pulse1_level_k%0d", k), 32'(a_level),
            (k >= c_LAT && k < c_LAT + c_H) ? 32'h3 : 32'h1);
      check($sformatf("pulse1_pos_k%0d", k), 32'(a_posedge), (k == c_LAT + 1) ? 32'h2 : 32'h0);
      check($sformatf("pulse1_neg_k%0d", k), 32'(a_negedge), (k == c_LAT + c_H + 1) ? 32'h2 : 32'h0);
      check($sformatf("pulse1_both_k%0d", k), 32'(a_bothedge),
            (k == c_LAT + 1 || k == c_LAT + c_H + 1) ? 32'h2 : 32'h0);
    end

    // Channel 2 toggling every cycle
    for (int k = 1; k <= 14; k++) begin
      if (k <= 10) a[2] = ~a[2];
      else a[2] = 1'b0;
      step();
      check($sformatf("toggle2_excl_k%0d", k), 32'(a_posedge & a_negedge), 32'h0);
      check($sformatf("toggle2_both_k%0d", k), 32'(a_bothedge), 32'(a_posedge | a_negedge));
    end

    // Channel 3: establish both sticky flags
    check("ch3_evt_init", {30'h0, evt_pos[3], evt_neg[3]}, 32'h0);
    a[3] = 1'b1;
    for (int k = 1; k <= c_LAT + c_H + 2; k++) begin
      step();
      if (k == c_H) a[3] = 1'b0;
    end
    check("ch3_evt_set", {30'h0, evt_pos[3], evt_neg[3]}, 32'h3);

    // Second pulse, clr lands on the same edge as the new negedge
    a[3] = 1'b1;
    for (int k = 1; k <= c_LAT + c_H + 2; k++) begin
      step();
      if (k == c_H) a[3] = 1'b0;
      if (k == c_LAT + c_H + 1) begin
        check("ch3_neg_pulse", 32'(a_negedge[3]), 32'h1);
        check("ch3_setwins", {30'h0, evt_pos[3], evt_neg[3]}, 32'h1);
      end
      if (k == c_LAT + c_H + 2) begin
        check("ch3_cleared", {30'h0, evt_pos[3], evt_neg[3]}, 32'h0);
        clr = 4'b0000;
      end
      if (k == c_LAT + c_H) clr = 4'b1000;
    end

    // All channels high through reset
    #2;
    rst_n = 1'b0;
    a     = 4'b1111;
    #1;
    check("async_reset_all", all_out(), 32'h0);
    step();
    step();
    check("held_reset_all", all_out(), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= c_LAT + 2; k++) begin
      step();
      check($sformatf("all_level_k%0d", k), 32'(a_level), (k >= c_LAT) ? 32'hF : 32'h0);
      check($sformatf("all_pos_k%0d", k), 32'(a_posedge), (k == c_LAT + 1) ? 32'hF : 32'h0);
    end

    // Reset mid-qualification aborts the pending edge
    a = 4'b0000;
    for (int k = 1; k <= c_LAT + 3; k++) step();
    check("settle_low", 32'(a_level), 32'h0);
    a = 4'b0001;
    for (int k = 1; k <= c_STAGES + 1; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async_reset", all_out(), 32'h0);
    a = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= c_LAT + 4; k++) begin
      step();
      check($sformatf("abort_quiet_k%0d", k), {24'h0, a_level, a_posedge}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_edge_det.md
SYNC_EDGE_DET -- requirements
Module: sync_edge_det

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels, legal 1..32.
REQ-002 Parameter STAGES, default 2: synchroniser flop depth per channel, legal 2..4.
REQ-003 Parameter DB_CYCLES, default 4: debounce stability window in clk cycles, legal 2..255; used only with DEBOUNCE_EN.
REQ-004 clk  input  1  single clock; all flops rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  WIDTH  asynchronous channel inputs.
REQ-007 clr  input  WIDTH  synchronous per-channel clear of sticky event flags.
REQ-008 a_level  output  WIDTH  synchronised (and filtered) level per channel.
REQ-009 a_posedge  output  WIDTH  one-cycle pulse on a_level 0->1.
REQ-010 a_negedge  output  WIDTH  one-cycle pulse on a_level 1->0.
REQ-011 a_bothedge  output  WIDTH  a_posedge | a_negedge, registered together with them.
REQ-012 evt_pos  output  WIDTH  sticky flag, set by a_posedge.
REQ-013 evt_neg  output  WIDTH  sticky flag, set by a_negedge.

Function
REQ-014 Each channel SHALL pass a[i] through a STAGES-deep flop chain; last stage = s[i].
REQ-015 Channels SHALL be fully independent; no cross-channel logic.
REQ-016 Filtered level f[i] SHALL drive a_level[i]; without filtering f[i] = s[i].
REQ-017 Edge outputs SHALL be registered: on the clock edge after f[i] changes, a_posedge[i] (rise) or a_negedge[i] (fall) and a_bothedge[i] SHALL be 1 for exactly one cycle.
REQ-018 Latency without filter: a[i] stable before edge 1 -> a_level[i] changes after edge STAGES -> edge pulse high after edge STAGES+1, low after edge STAGES+2.
REQ-019 Input toggling every cycle SHALL produce at most one pulse per f[i] transition, never simultaneous posedge and negedge on one channel.
REQ-020 evt_pos[i]/evt_neg[i] SHALL set on the cycle the matching pulse is registered and hold until clr[i] = 1 at a rising edge.
REQ-021 Simultaneous set and clr[i] on the same edge: set SHALL win, flag stays 1.
REQ-022 clr[i] SHALL clear both evt_pos[i] and evt_neg[i]; no effect on a_level or pulses.

Reset
REQ-023 rst_n = 0 SHALL immediately force all sync flops, f, debounce counters, pulses and sticky flags to 0.
REQ-024 If a[i] = 1 at reset release, the channel SHALL produce one a_posedge[i] pulse per REQ-018 (reset level is 0).
REQ-025 Reset asserted mid-debounce or mid-pulse SHALL abort it; no pulse after release unless re-qualified.

Configuration
REQ-026 Macro DEBOUNCE_EN defined: per-channel 8-bit counter; counter increments each cycle s[i] != f[i]; cleared when s[i] == f[i]; when counter = DB_CYCLES-1 and s[i] != f[i], f[i] <= s[i] and counter <= 0.
REQ-027 With DEBOUNCE_EN, a_level latency SHALL be STAGES+DB_CYCLES edges, pulse STAGES+DB_CYCLES+1; glitches shorter than DB_CYCLES cycles at s[i] SHALL produce no change and no pulse.
REQ-028 DEBOUNCE_EN undefined: no counters instantiated, f[i] = s[i], DB_CYCLES ignored.

Verification (WIDTH=4, STAGES=2, DB_CYCLES=4)
REQ-029 No DEBOUNCE_EN, rst_n released, a=4'b0001 before edge 1 -> a_level[0]=1 after edge 2; a_posedge=4'b0001 after edge 3 only; evt_pos=4'b0001 from edge 3.
REQ-030 No DEBOUNCE_EN, a[1] 1 for 2 cycles then 0 -> one a_posedge[1] then one a_negedge[1] two cycles apart; a_bothedge[1] pulses twice.
REQ-031 DEBOUNCE_EN, a[2] high 3 cycles then low -> a_level[2] stays 0, no pulses; a[2] high 10 cycles -> a_level[2]=1 after edge 6, a_posedge[2] after edge 7.
REQ-032 evt_neg[3] set, clr[3]=1 on same edge as a new a_negedge[3] -> evt_neg[3] stays 1; clr[3] next cycle alone -> evt_neg[3]=0, evt_pos[3]=0.
REQ-033 a=4'b1111 held through reset -> after release all four channels pulse a_posedge together per REQ-018/027.
REQ-034 rst_n pulsed low during DEBOUNCE_EN window on a[0] -> all outputs 0 asynchronously; a[0] dropped before release -> no pulse afterwards.
